// File: rtl/hazard_pkg.sv
// Shared types for the ID/EX hazard controller and the EX-stage operand muxes.
package hazard_pkg;
    typedef enum logic [1:0] {RUN, LU_STALL, BR_FLUSH} hz_state_t;
    typedef enum logic [1:0] {FWD_RF, FWD_EXMEM, FWD_MEMWB} fwd_sel_t;

    localparam int CNT_W = 3;

    // Counter preload for an N-cycle event: the entry cycle is spent in RUN.
    function automatic logic [CNT_W-1:0] cnt_preload(input int cycles);
        return CNT_W'(cycles - 1);
    endfunction
endpackage

// File: rtl/id_ex_hazard_ctrl_if.sv
// Decode/EX/MEM hazard inputs and the stall/flush/forward controls they produce.
interface id_ex_hazard_ctrl_if #(
    parameter int REG_ADDR_W = 3
);
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_uses_rs2;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_mem_read;
    logic                  ex_rf_write_en;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic                  mem_rf_write_en;
    logic                  branch_taken;
    logic                  pc_stall;
    logic                  if_id_stall;
    logic                  id_ex_bubble;
    logic                  if_id_flush;
    logic [1:0]            fwd_sel_a;
    logic [1:0]            fwd_sel_b;

    modport master (
        output id_rs1, id_rs2, id_uses_rs2, ex_rd, ex_mem_read, ex_rf_write_en,
               mem_rd, mem_rf_write_en, branch_taken,
        input  pc_stall, if_id_stall, id_ex_bubble, if_id_flush, fwd_sel_a, fwd_sel_b
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs2, ex_rd, ex_mem_read, ex_rf_write_en,
               mem_rd, mem_rf_write_en, branch_taken,
        output pc_stall, if_id_stall, id_ex_bubble, if_id_flush, fwd_sel_a, fwd_sel_b
    );
endinterface

// File: rtl/hazard_cmp.sv
// Register-index comparator: does the decode instruction read one stage's destination?
module hazard_cmp #(
    parameter int REG_ADDR_W = 3
) (
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    input  logic                  uses_rs2,
    input  logic [REG_ADDR_W-1:0] rd,
    output logic                  hit1,
    output logic                  hit2
);
    // R0 is an ordinary register here, so no zero-index exemption.
    assign hit1 = (rs1 == rd);
    assign hit2 = uses_rs2 & (rs2 == rd);
endmodule

// File: rtl/id_ex_hazard_ctrl.sv
// Load-use stall and taken-branch flush control beside the ID/EX register.
// Build option FORWARDING_EN: ALU RAW hazards are forwarded instead of stalled.
module id_ex_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W     = 3,
    parameter int LOAD_USE_STALL = 1,
    parameter int BRANCH_FLUSH   = 2
) (
    input logic                clk,
    input logic                rst,
    id_ex_hazard_ctrl_if.slave hz
);
    localparam logic [CNT_W-1:0] LU_LOAD  = cnt_preload(LOAD_USE_STALL);
    localparam logic [CNT_W-1:0] BR_LOAD  = cnt_preload(BRANCH_FLUSH);
    localparam bit               LU_MULTI = (LOAD_USE_STALL > 1);
    localparam bit               BR_MULTI = (BRANCH_FLUSH > 1);

    hz_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             ex_hit1, ex_hit2, mem_hit1, mem_hit2;
    logic             ex_load, ex_alu, ex_raw;
    logic             long_stall, short_stall;
    logic             pc_stall, if_id_stall, id_ex_bubble, if_id_flush;

    hazard_cmp #(.REG_ADDR_W(REG_ADDR_W)) u_cmp_ex (
        .rs1      (hz.id_rs1),
        .rs2      (hz.id_rs2),
        .uses_rs2 (hz.id_uses_rs2),
        .rd       (hz.ex_rd),
        .hit1     (ex_hit1),
        .hit2     (ex_hit2)
    );

    hazard_cmp #(.REG_ADDR_W(REG_ADDR_W)) u_cmp_mem (
        .rs1      (hz.id_rs1),
        .rs2      (hz.id_rs2),
        .uses_rs2 (hz.id_uses_rs2),
        .rd       (hz.mem_rd),
        .hit1     (mem_hit1),
        .hit2     (mem_hit2)
    );

    assign ex_load = hz.ex_mem_read & hz.ex_rf_write_en;
    assign ex_alu  = hz.ex_rf_write_en & ~hz.ex_mem_read;
    assign ex_raw  = ex_hit1 | ex_hit2;

`ifdef FORWARDING_EN
    assign long_stall  = ex_load & ex_raw;
    assign short_stall = 1'b0;
`else
    // Without forwarding every EX producer stalls the full length; a MEM-only hit needs one cycle.
    assign long_stall  = (ex_load | ex_alu) & ex_raw;
    assign short_stall = hz.mem_rf_write_en & (mem_hit1 | mem_hit2);
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // A taken branch overrides everything, including an in-progress stall.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (hz.branch_taken) begin
            state_nxt = BR_MULTI ? BR_FLUSH : RUN;
            cnt_nxt   = BR_MULTI ? BR_LOAD : '0;
        end else begin
            case (state)
                RUN: begin
                    if (long_stall && LU_MULTI) begin
                        state_nxt = LU_STALL;
                        cnt_nxt   = LU_LOAD;
                    end
                end
                LU_STALL, BR_FLUSH: begin
                    if (cnt <= CNT_W'(1)) begin
                        state_nxt = RUN;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
                default: begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        if (hz.branch_taken || state == BR_FLUSH) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (state == LU_STALL || long_stall || short_stall) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_bubble = 1'b1;
        end
    end

    assign hz.pc_stall     = pc_stall;
    assign hz.if_id_stall  = if_id_stall;
    assign hz.id_ex_bubble = id_ex_bubble;
    assign hz.if_id_flush  = if_id_flush;

`ifdef FORWARDING_EN
    fwd_sel_t fwd_a_nxt, fwd_b_nxt, fwd_a_q, fwd_b_q;

    // The EX producer moves to EX/MEM and the MEM producer to MEM/WB as decode enters EX.
    always_comb begin
        fwd_a_nxt = FWD_RF;
        fwd_b_nxt = FWD_RF;
        if (ex_alu && ex_hit1)                   fwd_a_nxt = FWD_EXMEM;
        else if (hz.mem_rf_write_en && mem_hit1) fwd_a_nxt = FWD_MEMWB;
        if (ex_alu && ex_hit2)                   fwd_b_nxt = FWD_EXMEM;
        else if (hz.mem_rf_write_en && mem_hit2) fwd_b_nxt = FWD_MEMWB;
    end

    always_ff @(posedge clk) begin
        if (!rst || id_ex_bubble) begin
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
        end else begin
            fwd_a_q <= fwd_a_nxt;
            fwd_b_q <= fwd_b_nxt;
        end
    end

    assign hz.fwd_sel_a = fwd_a_q;
    assign hz.fwd_sel_b = fwd_b_q;
`else
    assign hz.fwd_sel_a = 2'b00;
    assign hz.fwd_sel_b = 2'b00;
`endif
endmodule
